// File: rtl/ccr_flag_controller.sv
// Condition-code register {N,C,Z}: per-opcode flag commit, same-cycle bypass for
// conditional jumps, jump-taken flag clear, and a shadow stack for interrupt save/RTI.
module ccr_flag_controller #(
   parameter int DEPTH = 2,
   parameter int PW    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ex_valid,
   input  logic       stall,
   input  logic [3:0] aluControl,
   input  logic [2:0] alu_flag,
   input  logic       jmp_en,
   input  logic [1:0] jmp_type,
   input  logic       int_save,
   input  logic       rti_restore,
   output logic [2:0] ccr,
   output logic [2:0] eff_flag,
   output logic       jump_taken,
   output logic       stack_ovf,
   output logic       stack_unf
);

   localparam logic [3:0] OP_NOT  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_INC  = 4'b0111;
   localparam logic [3:0] OP_DEC  = 4'b1000;
   localparam logic [3:0] OP_CLRC = 4'b1001;
   localparam logic [3:0] OP_SETC = 4'b1010;
   localparam logic [3:0] OP_SHL  = 4'b1011;
   localparam logic [3:0] OP_SHR  = 4'b1100;

   localparam logic [1:0] J_Z   = 2'b00;
   localparam logic [1:0] J_N   = 2'b01;
   localparam logic [1:0] J_C   = 2'b10;

   localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
   localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

   logic             upd;
   logic [2:0]       wr_mask;
   logic [2:0]       wr_val;
   logic             cond;
   logic [2:0]       clr_mask;
   logic [2:0]       normal_next;

   // cnt carries one extra bit so that "full" (cnt==DEPTH) is distinguishable from empty
   logic [PW:0]           cnt;
   logic [PW:0]           cnt_dec;
   logic [DEPTH-1:0][2:0] stack;
   logic [2:0]            pop_val;
   logic                  full;
   logic                  empty;
   logic                  push_ok;
   logic                  push_drop;
   logic                  pop_ok;
   logic                  pop_drop;

   assign upd = ex_valid & ~stall;

   always_comb begin
      wr_mask = 3'b000;
      wr_val  = 3'b000;
      case (aluControl)
         OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_SHL, OP_SHR: begin
            wr_mask = 3'b111;
            wr_val  = alu_flag;
         end
         OP_NOT, OP_AND, OP_OR: begin
            wr_mask = 3'b101;
            wr_val  = alu_flag;
         end
         OP_SETC: begin
            wr_mask = 3'b010;
            wr_val  = 3'b010;
         end
         OP_CLRC: begin
            wr_mask = 3'b010;
            wr_val  = 3'b000;
         end
         default: begin
            wr_mask = 3'b000;
            wr_val  = 3'b000;
         end
      endcase
      if (!upd) wr_mask = 3'b000;
   end

   assign eff_flag = (ccr & ~wr_mask) | (wr_val & wr_mask);

   always_comb begin
      cond     = 1'b1;
      clr_mask = 3'b000;
      case (jmp_type)
         J_Z: begin
            cond     = eff_flag[0];
            clr_mask = 3'b001;
         end
         J_N: begin
            cond     = eff_flag[2];
            clr_mask = 3'b100;
         end
         J_C: begin
            cond     = eff_flag[1];
            clr_mask = 3'b010;
         end
         default: begin
            cond     = 1'b1;
            clr_mask = 3'b000;
         end
      endcase
   end

   assign jump_taken  = jmp_en & upd & cond;
   assign normal_next = jump_taken ? (eff_flag & ~clr_mask) : eff_flag;

   // A simultaneous save and restore cancels out: neither touches the stack
   assign full      = (cnt == CNT_FULL);
   assign empty     = (cnt == '0);
   assign push_ok   = ~stall & int_save & ~rti_restore & ~full;
   assign push_drop = ~stall & int_save & ~rti_restore &  full;
   assign pop_ok    = ~stall & rti_restore & ~int_save & ~empty;
   assign pop_drop  = ~stall & rti_restore & ~int_save &  empty;
   assign cnt_dec   = cnt - CNT_ONE;

   always_comb begin
      pop_val = 3'b000;
      for (int i = 0; i < DEPTH; i++) begin
         if (cnt_dec == (PW+1)'(i)) pop_val = stack[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ccr       <= 3'b000;
         cnt       <= '0;
         stack     <= '0;
         stack_ovf <= 1'b0;
         stack_unf <= 1'b0;
      end else if (!stall) begin
         ccr <= pop_ok ? pop_val : normal_next;
         if (push_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (cnt == (PW+1)'(i)) stack[i] <= ccr;
            end
            cnt <= cnt + CNT_ONE;
         end else if (pop_ok) begin
            cnt <= cnt_dec;
         end
         if (push_drop) stack_ovf <= 1'b1;
         if (pop_drop)  stack_unf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ccr_flag_controller.sv
// Directed walk through the CCR scenarios followed by random traffic, all checked
// against a flag/stack model built from opcode tables and a queue.
module tb_ccr_flag_controller;

   localparam int DEPTH = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ex_valid = 1'b0;
   logic       stall = 1'b0;
   logic [3:0] aluControl = 4'h0;
   logic [2:0] alu_flag = 3'b000;
   logic       jmp_en = 1'b0;
   logic [1:0] jmp_type = 2'b00;
   logic       int_save = 1'b0;
   logic       rti_restore = 1'b0;
   logic [2:0] ccr;
   logic [2:0] eff_flag;
   logic       jump_taken;
   logic       stack_ovf;
   logic       stack_unf;

   int n_checks = 0;
   int n_errors = 0;

   logic [2:0] m_ccr = 3'b000;
   logic [2:0] m_stk[$];
   bit         m_ovf = 1'b0;
   bit         m_unf = 1'b0;

   ccr_flag_controller #(.DEPTH(DEPTH), .PW(1)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .stall(stall),
      .aluControl(aluControl), .alu_flag(alu_flag), .jmp_en(jmp_en),
      .jmp_type(jmp_type), .int_save(int_save), .rti_restore(rti_restore),
      .ccr(ccr), .eff_flag(eff_flag), .jump_taken(jump_taken),
      .stack_ovf(stack_ovf), .stack_unf(stack_unf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [2:0] m_eff(input logic [2:0] c, input bit u,
                                        input logic [3:0] op, input logic [2:0] af);
      if (!u) return c;
      case (op)
         4'h2, 4'h4, 4'h7, 4'h8, 4'hB, 4'hC: return af;
         4'h1, 4'h5, 4'h6:                   return {af[2], c[1], af[0]};
         4'hA:                               return {c[2], 1'b1, c[0]};
         4'h9:                               return {c[2], 1'b0, c[0]};
         default:                            return c;
      endcase
   endfunction

   // One cycle: drive after the edge, check at the falling edge, then advance the model
   task automatic cyc(input bit r, input bit ex, input bit st, input logic [3:0] op,
                      input logic [2:0] af, input bit je, input logic [1:0] jt,
                      input bit sv, input bit rt);
      logic [2:0] e;
      logic [2:0] nxt;
      bit         u;
      bit         tk;
      int         bitpos;
      @(posedge clk);
      #1;
      rst = r; ex_valid = ex; stall = st; aluControl = op; alu_flag = af;
      jmp_en = je; jmp_type = jt; int_save = sv; rti_restore = rt;
      @(negedge clk);
      u = ex && !st;
      e = m_eff(m_ccr, u, op, af);
      bitpos = (jt == 2'd0) ? 0 : (jt == 2'd1) ? 2 : 1;
      tk = je && u && ((jt == 2'd3) ? 1'b1 : e[bitpos]);
      chk("ccr", ccr, m_ccr);
      chk("eff_flag", eff_flag, e);
      chk("jump_taken", jump_taken, tk);
      chk("stack_ovf", stack_ovf, m_ovf);
      chk("stack_unf", stack_unf, m_unf);
      nxt = e;
      if (tk && jt != 2'd3) nxt[bitpos] = 1'b0;
      if (r) begin
         m_ccr = 3'b000; m_stk.delete(); m_ovf = 0; m_unf = 0;
      end else if (!st) begin
         if (sv && rt) begin
            m_ccr = nxt;
         end else if (rt) begin
            if (m_stk.size() == 0) begin
               m_unf = 1; m_ccr = nxt;
            end else begin
               m_ccr = m_stk.pop_back();
            end
         end else begin
            if (sv) begin
               if (m_stk.size() == DEPTH) m_ovf = 1;
               else m_stk.push_back(m_ccr);
            end
            m_ccr = nxt;
         end
      end
   endtask

   task automatic idle();
      cyc(0, 0, 0, 4'h0, 3'b000, 0, 2'b00, 0, 0);
   endtask

   initial begin
      // reset and basic commit / held-C
      cyc(1, 0, 0, 4'h0, 3'b000, 0, 2'b00, 0, 0);
      idle();
      chk("rst_ccr", ccr, 3'b000);
      chk("rst_ovf", stack_ovf, 1'b0);
      cyc(0, 1, 0, 4'h2, 3'b010, 0, 2'b00, 0, 0);
      chk("add_bypass", eff_flag, 3'b010);
      cyc(0, 1, 0, 4'h5, 3'b101, 0, 2'b00, 0, 0);
      idle();
      chk("and_hold_c", ccr, 3'b111);

      // JZ through the bypass
      cyc(0, 1, 0, 4'h4, 3'b001, 0, 2'b00, 0, 0);
      cyc(0, 1, 0, 4'h4, 3'b000, 1, 2'b00, 0, 0);
      chk("jz_not_taken", jump_taken, 1'b0);
      idle();
      chk("jz_nt_ccr", ccr, 3'b000);
      cyc(0, 1, 0, 4'h4, 3'b001, 1, 2'b00, 0, 0);
      chk("jz_taken", jump_taken, 1'b1);
      idle();
      chk("jz_clear", ccr, 3'b000);

      // SETC, JC clear, stall freeze
      cyc(0, 1, 0, 4'hA, 3'b000, 0, 2'b00, 0, 0);
      idle();
      chk("setc", ccr, 3'b010);
      cyc(0, 1, 0, 4'h0, 3'b000, 1, 2'b10, 0, 0);
      chk("jc_taken", jump_taken, 1'b1);
      cyc(0, 1, 1, 4'h2, 3'b111, 1, 2'b11, 1, 0);
      chk("stall_jump", jump_taken, 1'b0);
      idle();
      chk("stall_hold", ccr, 3'b000);

      // save / ISR / restore
      cyc(0, 1, 0, 4'h2, 3'b101, 0, 2'b00, 0, 0);
      cyc(0, 0, 0, 4'h0, 3'b000, 0, 2'b00, 1, 0);
      cyc(0, 1, 0, 4'h2, 3'b010, 0, 2'b00, 0, 0);
      idle();
      chk("isr_ccr", ccr, 3'b010);
      cyc(0, 0, 0, 4'h0, 3'b000, 0, 2'b00, 0, 1);
      idle();
      chk("rti_ccr", ccr, 3'b101);

      // overflow then underflow at DEPTH=2
      cyc(0, 1, 0, 4'h2, 3'b001, 0, 2'b00, 0, 0);
      cyc(0, 1, 0, 4'h2, 3'b010, 0, 2'b00, 1, 0);
      cyc(0, 1, 0, 4'h2, 3'b100, 0, 2'b00, 1, 0);
      cyc(0, 0, 0, 4'h0, 3'b000, 0, 2'b00, 1, 0);
      idle();
      chk("ovf_set", stack_ovf, 1'b1);
      cyc(0, 0, 0, 4'h0, 3'b000, 0, 2'b00, 0, 1);
      idle();
      chk("pop1", ccr, 3'b010);
      cyc(0, 0, 0, 4'h0, 3'b000, 0, 2'b00, 0, 1);
      idle();
      chk("pop2", ccr, 3'b001);
      cyc(0, 0, 0, 4'h0, 3'b000, 0, 2'b00, 0, 1);
      idle();
      chk("unf_set", stack_unf, 1'b1);
      chk("unf_ccr", ccr, 3'b001);

      // reset mid-sequence with a saved level
      cyc(1, 0, 0, 4'h0, 3'b000, 0, 2'b00, 0, 0);
      cyc(0, 1, 0, 4'h2, 3'b111, 0, 2'b00, 1, 0);
      cyc(1, 1, 0, 4'h2, 3'b010, 1, 2'b11, 1, 0);
      idle();
      chk("mid_rst_ccr", ccr, 3'b000);
      chk("mid_rst_ovf", stack_ovf, 1'b0);
      cyc(0, 0, 0, 4'h0, 3'b000, 0, 2'b00, 0, 1);
      idle();
      chk("post_rst_unf", stack_unf, 1'b1);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 5) == 0, 4'($urandom), 3'($urandom),
             $urandom_range(0, 2) == 0, 2'($urandom),
             $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ccr_flag_controller.md
Name: ccr_flag_controller

Overview:
- Owns the 3-bit condition-code register {N,C,Z} fed by the execute-stage ALU flag outputs.
- Decides per aluControl which flags commit, and evaluates conditional jumps against bypassed flags.
- Clears the tested flag when a conditional jump is taken.
- Saves and restores the CCR on interrupt entry and RTI through a small shadow stack.

Parameters:
- DEPTH, 2, shadow-stack entries (nested interrupt levels); power of two, at least 1
- PW, 1, stack-pointer width, equal to log2(DEPTH)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  execute stage holds a valid instruction this cycle
- stall  in  1  pipeline freeze; when high, no state changes except reset
- aluControl  in  4  ALU operation code of the instruction in execute
- alu_flag  in  3  ALU flag result {N,C,Z} (bit2=N, bit1=C, bit0=Z)
- jmp_en  in  1  instruction in execute is a jump
- jmp_type  in  2  00 JZ, 01 JN, 10 JC, 11 JMP (unconditional)
- int_save  in  1  single-cycle pulse, interrupt entry: push CCR
- rti_restore  in  1  single-cycle pulse, RTI: pop CCR
- ccr  out  3  registered flags {N,C,Z}
- eff_flag  out  3  combinational bypassed flags (ccr with this cycle's ALU update applied)
- jump_taken  out  1  combinational branch decision
- stack_ovf  out  1  sticky: push attempted while stack full
- stack_unf  out  1  sticky: pop attempted while stack empty

Behaviour:
- Reset: ccr=000, stack pointer=0, all stack entries=000, stack_ovf=0, stack_unf=0. Reset overrides every other input in the same cycle.
- upd = ex_valid & ~stall.
- Update masks by aluControl:
  - 0010 ADD, 0100 SUB, 0111 INC, 1000 DEC, 1011 SHL, 1100 SHR: N, C and Z take alu_flag.
  - 0001 NOT, 0101 AND, 0110 OR: N and Z take alu_flag; C is held.
  - 1010 SETC: C=1, N and Z held.
  - 1001 CLRC: C=0, N and Z held.
  - 0000, 0011, 1111 and all undefined codes: no flag change.
- eff_flag = ccr with the mask applied when upd=1, else ccr. Zero-latency bypass, so a jump reads the flags of the instruction ahead of it in the same cycle.
- Jump decision:
  - jump_taken = jmp_en & ex_valid & ~stall & cond.
  - cond: JZ uses eff_flag[0], JN uses eff_flag[2], JC uses eff_flag[1], JMP is 1.
- Taken JZ, JN or JC clears the tested flag in the next ccr; other flags come from eff_flag. JMP and not-taken jumps write eff_flag unchanged.
- Next-ccr priority, highest first:
  1. rst
  2. stall (hold everything)
  3. rti_restore (ccr = popped entry; the same-cycle ALU update and jump-clear are discarded)
  4. normal path (eff_flag plus jump-clear)
- int_save (not stalled):
  - Pushes the current registered ccr (pre-update value) into the entry at the pointer, then pointer+1.
  - The normal ccr update still commits in that cycle.
- rti_restore (not stalled):
  - Pointer-1, then ccr = the entry at the new pointer.
- int_save and rti_restore in the same cycle: the pair is a no-op on the stack and on ccr. The normal update still applies.
- Push when full (pointer==DEPTH, tracked with an extra count bit): the push is dropped, stack_ovf is set, ccr update proceeds normally.
- Pop when empty: the pop is dropped, ccr is unchanged by the restore, the normal path applies, stack_unf is set.
- stack_ovf and stack_unf clear only on rst.
- Stack entries are not cleared on pop. Reads occur only at valid pointers.
- Outputs are the registered ccr (1-cycle visibility after the update edge) and combinational eff_flag/jump_taken. There are no other pipeline delays.

Test Plan:
- Reset, then ADD with alu_flag=010, ex_valid=1 -> eff_flag=010 that cycle; ccr=010 next cycle; then AND with alu_flag=101 -> ccr=111 (C held).
- ccr=001; same-cycle SUB alu_flag=000 plus JZ -> jump_taken=0 via bypass; next ccr=000. Repeat with alu_flag=001 -> jump_taken=1, ccr=000 (Z cleared).
- SETC -> ccr=x1x; JC -> jump_taken=1, C cleared; stall=1 with ADD alu_flag=111 -> ccr unchanged, jump_taken=0.
- ccr=101, int_save; ISR ADD alu_flag=010 -> ccr=010; rti_restore -> ccr=101 next cycle.
- DEPTH=2: three int_save with ccr 001, 010, 100 -> third sets stack_ovf=1; two rti -> ccr=010 then 001; third rti -> stack_unf=1, ccr unchanged.
- rst asserted mid-sequence while saved depth=1 and ccr=111 -> next cycle ccr=000, pointer 0, flags 0; a following rti sets stack_unf.
